// File: rtl/max7219_pkg.sv
// Register map and Code-B segment table for the MAX7219-style link; shared by the
// receiver and the transmitter.
package max7219_pkg;

    localparam logic [3:0] REG_NOOP         = 4'h0;
    localparam logic [3:0] REG_DIGIT_FIRST  = 4'h1;
    localparam logic [3:0] REG_DIGIT_LAST   = 4'h8;
    localparam logic [3:0] REG_DECODE_MODE  = 4'h9;
    localparam logic [3:0] REG_INTENSITY    = 4'hA;
    localparam logic [3:0] REG_SCAN_LIMIT   = 4'hB;
    localparam logic [3:0] REG_SHUTDOWN     = 4'hC;
    localparam logic [3:0] REG_UNUSED_D     = 4'hD;
    localparam logic [3:0] REG_UNUSED_E     = 4'hE;
    localparam logic [3:0] REG_DISPLAY_TEST = 4'hF;

    localparam int FRAME_BITS = 16;

    typedef enum logic [2:0] {
        ST_WARMUP,
        ST_WAIT_IDLE,
        ST_IDLE,
        ST_FRAME,
        ST_EVAL
    } rx_state_t;

    // Segment order is A..G from bit 6 down to bit 0.
    function automatic logic [6:0] codeb_segments(input logic [3:0] code);
        logic [6:0] seg;
        case (code)
            4'h0:    seg = 7'h7E;
            4'h1:    seg = 7'h30;
            4'h2:    seg = 7'h6D;
            4'h3:    seg = 7'h79;
            4'h4:    seg = 7'h33;
            4'h5:    seg = 7'h5B;
            4'h6:    seg = 7'h5F;
            4'h7:    seg = 7'h70;
            4'h8:    seg = 7'h7F;
            4'h9:    seg = 7'h7B;
            4'hA:    seg = 7'h01;
            4'hB:    seg = 7'h4F;
            4'hC:    seg = 7'h37;
            4'hD:    seg = 7'h0E;
            4'hE:    seg = 7'h67;
            default: seg = 7'h00;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/max7219_codeb.sv
// Code-B decoder for one digit: DP passes through on bit 7, bits 6..0 drive segments A..G.
module max7219_codeb
    import max7219_pkg::*;
(
    input  logic       dp,
    input  logic [3:0] code,
    output logic [7:0] seg
);

    assign seg = {dp, codeb_segments(code)};

endmodule

// File: rtl/max7219_rx.sv
// MAX7219-compatible serial receiver with register file and daisy-chain output.
// Define MAX7219_RX_DECODE_EN to enable per-digit Code-B decoding of the digit outputs.
module max7219_rx
    import max7219_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sclk,
    input  logic        mosi,
    input  logic        sel,
    output logic        dout,
    output logic [63:0] digits,
    output logic [7:0]  decode_mode,
    output logic [3:0]  intensity,
    output logic [2:0]  scan_limit,
    output logic        shutdown,
    output logic        display_test,
    output logic        frame_valid,
    output logic        frame_err
);

    logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, sel_sync, warm_sr;
    logic                   sclk_q, sel_q;
    logic                   sclk_s, mosi_s, sel_s, warm_done;
    logic                   sclk_rise, sclk_fall, sel_rise, sel_fall;
    logic                   frame_active, sclk_take;

    logic [15:0]            shreg;
    logic [4:0]             bit_cnt;
    logic [7:0][7:0]        digit_raw;
    logic                   do_eval, accept;
    logic [3:0]             addr;
    logic [7:0]             data;

    rx_state_t              state, state_nxt;

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sel_s     = sel_sync[SYNC_STAGES-1];
    assign warm_done = warm_sr[SYNC_STAGES-1];

    assign sclk_rise = sclk_s & ~sclk_q;
    assign sclk_fall = ~sclk_s & sclk_q;
    assign sel_rise  = sel_s & ~sel_q;
    assign sel_fall  = ~sel_s & sel_q;

    // The cycle in which sel rises still belongs to the frame, so a coincident
    // sclk edge is counted before the frame is evaluated.
    assign frame_active = ~sel_s | ~sel_q;
    assign sclk_take    = sclk_rise & frame_active;

    // warm_sr marks when the synchronizer outputs hold real pin samples rather
    // than the reset fill, so a sel already low at reset is not seen as a new frame.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!rst_n) begin
            sclk_sync <= '0;
            mosi_sync <= '0;
            sel_sync  <= '1;
            warm_sr   <= '0;
            sclk_q    <= 1'b0;
            sel_q     <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sel_sync  <= {sel_sync[SYNC_STAGES-2:0], sel};
            warm_sr   <= {warm_sr[SYNC_STAGES-2:0], 1'b1};
            sclk_q    <= sclk_s;
            sel_q     <= sel_s;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_WARMUP;
        else        state <= state_nxt;
    end

    always_comb begin
        // NOTE: defaults first so no path leaves a variable unassigned and
        // infers a latch.
        state_nxt = state;
        do_eval   = 1'b0;
        case (state)
            ST_WARMUP:    if (warm_done) state_nxt = sel_s ? ST_IDLE : ST_WAIT_IDLE;
            ST_WAIT_IDLE: if (sel_s) state_nxt = ST_IDLE;
            ST_IDLE:      if (sel_fall) state_nxt = ST_FRAME;
            ST_FRAME:     if (sel_rise) state_nxt = ST_EVAL;
            ST_EVAL: begin
                do_eval   = 1'b1;
                state_nxt = sel_fall ? ST_FRAME : ST_IDLE;
            end
            default:      state_nxt = ST_WARMUP;
        endcase
    end

    assign addr   = shreg[11:8];
    assign data   = shreg[7:0];
    assign accept = do_eval & (bit_cnt >= 5'(FRAME_BITS));

    always_ff @(posedge clk) begin
        // NOTE: the digit storage is explicitly reset; a power-up display must
        // come up blank rather than showing whatever the flops hold.
        if (!rst_n) begin
            shreg        <= '0;
            bit_cnt      <= '0;
            dout         <= 1'b0;
            digit_raw    <= '0;
            decode_mode  <= '0;
            intensity    <= '0;
            scan_limit   <= '0;
            shutdown     <= 1'b1;
            display_test <= 1'b0;
            frame_valid  <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            if (sclk_take) begin
                shreg   <= {shreg[14:0], mosi_s};
                bit_cnt <= sel_fall ? 5'd1 : ((bit_cnt == 5'd31) ? 5'd31 : bit_cnt + 5'd1);
            end else if (sel_fall) begin
                bit_cnt <= '0;
            end

            if (sclk_fall && frame_active) dout <= shreg[15];

            frame_valid <= accept;
            frame_err   <= do_eval & ~accept;

            if (accept) begin
                case (addr)
                    REG_DECODE_MODE:  decode_mode  <= data;
                    REG_INTENSITY:    intensity    <= data[3:0];
                    REG_SCAN_LIMIT:   scan_limit   <= data[2:0];
                    REG_SHUTDOWN:     shutdown     <= ~data[0];
                    REG_DISPLAY_TEST: display_test <= data[0];
                    default: begin
                        if (addr >= REG_DIGIT_FIRST && addr <= REG_DIGIT_LAST)
                            digit_raw[3'(addr - 4'd1)] <= data;
                    end
                endcase
            end
        end
    end

`ifdef MAX7219_RX_DECODE_EN
    for (genvar n = 0; n < 8; n++) begin : g_digit
        logic [7:0] seg;
        max7219_codeb u_codeb (
            .dp   (digit_raw[n][7]),
            .code (digit_raw[n][3:0]),
            .seg  (seg)
        );
        assign digits[8*n +: 8] = decode_mode[n] ? seg : digit_raw[n];
    end
`else
    assign digits = digit_raw;
`endif

endmodule

// File: tb/tb_max7219_rx.sv
// Randomized bench for max7219_rx against a register-level model of the frame protocol.
module tb_max7219_rx;

    localparam int S = 2;
    localparam int H = 6;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sclk = 1'b0;
    logic        mosi = 1'b0;
    logic        sel = 1'b1;
    logic        dout;
    logic [63:0] digits;
    logic [7:0]  decode_mode;
    logic [3:0]  intensity;
    logic [2:0]  scan_limit;
    logic        shutdown, display_test, frame_valid, frame_err;

    max7219_rx #(.SYNC_STAGES(S)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sclk         (sclk),
        .mosi         (mosi),
        .sel          (sel),
        .dout         (dout),
        .digits       (digits),
        .decode_mode  (decode_mode),
        .intensity    (intensity),
        .scan_limit   (scan_limit),
        .shutdown     (shutdown),
        .display_test (display_test),
        .frame_valid  (frame_valid),
        .frame_err    (frame_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int valid_cnt = 0;
    int err_cnt = 0;
    int last_valid_cyc = 0;
    int n_checks = 0;
    int n_errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (frame_valid) begin
            valid_cnt      <= valid_cnt + 1;
            last_valid_cyc <= cyc;
        end
        if (frame_err) err_cnt <= err_cnt + 1;
    end

    // Reference model: register contents and the last 16 bits shifted since reset.
    logic [7:0] m_digit [8];
    logic [7:0] m_decode;
    logic [3:0] m_int;
    logic [2:0] m_scan;
    logic       m_shut, m_test;
    bit         hist[$];

`ifdef MAX7219_RX_DECODE_EN
    logic [6:0] seg_tbl [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                 7'h7F, 7'h7B, 7'h01, 7'h4F, 7'h37, 7'h0E, 7'h67, 7'h00};
`endif

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_digit[i] = 8'h00;
        m_decode = 8'h00;
        m_int    = 4'h0;
        m_scan   = 3'h0;
        m_shut   = 1'b1;
        m_test   = 1'b0;
        hist.delete();
    endtask

    function automatic logic [63:0] exp_digits();
        logic [63:0] r;
        r = '0;
        for (int n = 0; n < 8; n++) begin
`ifdef MAX7219_RX_DECODE_EN
            if (m_decode[n]) r[8*n +: 8] = {m_digit[n][7], seg_tbl[m_digit[n][3:0]]};
            else             r[8*n +: 8] = m_digit[n];
`else
            r[8*n +: 8] = m_digit[n];
`endif
        end
        return r;
    endfunction

    task automatic model_apply(input logic [15:0] w);
        int a;
        a = int'(w[11:8]);
        if (a >= 1 && a <= 8) m_digit[a-1] = w[7:0];
        else if (a == 9)      m_decode = w[7:0];
        else if (a == 10)     m_int    = w[3:0];
        else if (a == 11)     m_scan   = w[2:0];
        else if (a == 12)     m_shut   = ~w[0];
        else if (a == 15)     m_test   = w[0];
    endtask

    task automatic check_regs(input string ctx);
        check({ctx, ":digits"},       digits,       exp_digits());
        check({ctx, ":decode_mode"},  decode_mode,  m_decode);
        check({ctx, ":intensity"},    intensity,    m_int);
        check({ctx, ":scan_limit"},   scan_limit,   m_scan);
        check({ctx, ":shutdown"},     shutdown,     m_shut);
        check({ctx, ":display_test"}, display_test, m_test);
    endtask

    // Sends nbits of val MSB first in one sel-low window. With together set, the
    // last sclk rise and the sel rise are driven at the same instant.
    task automatic send_frame(input string ctx, input logic [31:0] val, input int nbits,
                              input bit together, output logic [31:0] dseq);
        int  v0, e0, rise;
        bit  b, last;
        dseq = '0;
        rise = 0;
        v0   = valid_cnt;
        e0   = err_cnt;
        sel  = 1'b0;
        tick(H);
        for (int i = 0; i < nbits; i++) begin
            b    = val[nbits-1-i];
            last = together && (i == nbits - 1);
            mosi = b;
            tick(H);
            sclk = 1'b1;
            if (last) begin
                sel  = 1'b1;
                rise = cyc;
            end
            hist.push_back(b);
            if (hist.size() > 16) void'(hist.pop_front());
            tick(H);
            sclk = 1'b0;
            tick(H);
            if (!last) begin
                check({ctx, ":dout"}, dout, (hist.size() == 16) ? hist[0] : 1'b0);
                dseq = {dseq[30:0], dout};
            end
        end
        if (!together) begin
            tick(H);
            sel  = 1'b1;
            rise = cyc;
        end
        tick(S + 6);
        if (nbits < 16) begin
            check({ctx, ":frame_err"},   err_cnt - e0,   1);
            check({ctx, ":frame_valid"}, valid_cnt - v0, 0);
        end else begin
            model_apply(val[15:0]);
            check({ctx, ":frame_valid"}, valid_cnt - v0, 1);
            check({ctx, ":frame_err"},   err_cnt - e0,   0);
            check({ctx, ":latency"},     last_valid_cyc - rise, S + 2);
        end
        check_regs(ctx);
    endtask

    initial begin
        logic [31:0] dseq;
        logic [31:0] rv;
        int          nb, v0, e0;

        model_reset();
        rst_n = 1'b0;
        tick(4);
        rst_n = 1'b1;
        tick(S + 4);
        check_regs("reset");
        check("reset:dout", dout, 1'b0);
        check("reset:strobes", valid_cnt + err_cnt, 0);

        send_frame("int7", 32'h0A07, 16, 1'b0, dseq);
        check("int7:intensity_val", intensity, 4'd7);

        send_frame("d3", 32'h0312, 16, 1'b0, dseq);
        send_frame("d8", 32'h08FF, 16, 1'b0, dseq);
        check("d3:byte", digits[23:16], 8'h12);
        check("d8:byte", digits[63:56], 8'hFF);

        send_frame("short12", 32'h0C01, 12, 1'b0, dseq);
        check("short12:shutdown", shutdown, 1'b1);
        send_frame("shut0", 32'h0C01, 16, 1'b0, dseq);
        check("shut0:shutdown", shutdown, 1'b0);

        send_frame("burst", 32'h0A05_0B03, 32, 1'b0, dseq);
        check("burst:scan_limit", scan_limit, 3'd3);
        check("burst:intensity", intensity, 4'd7);
        check("burst:dout_word", dseq[16:1], 16'h0A05);

        send_frame("decall", 32'h09FF, 16, 1'b0, dseq);
        send_frame("d1", 32'h0185, 16, 1'b0, dseq);
`ifdef MAX7219_RX_DECODE_EN
        check("d1:decoded", digits[7:0], 8'hDB);
`else
        check("d1:raw", digits[7:0], 8'h85);
`endif

        send_frame("together", 32'h0B05, 16, 1'b1, dseq);
        check("together:scan_limit", scan_limit, 3'd5);

        for (int k = 0; k < 25; k++) begin
            rv = $urandom;
            case ($urandom_range(0, 9))
                0, 1:    nb = int'($urandom_range(1, 15));
                2, 3:    nb = int'($urandom_range(17, 32));
                default: nb = 16;
            endcase
            send_frame($sformatf("rand%0d", k), rv, nb, 1'b0, dseq);
        end

        v0  = valid_cnt;
        e0  = err_cnt;
        sel = 1'b0;
        tick(H);
        for (int i = 0; i < 8; i++) begin
            mosi = 1'b1;
            tick(H);
            sclk = 1'b1;
            tick(H);
            sclk = 1'b0;
            tick(H);
        end
        rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;
        model_reset();
        tick(H);
        sel = 1'b1;
        tick(S + 6);
        check("midreset:valid", valid_cnt - v0, 0);
        check("midreset:err", err_cnt - e0, 0);
        check("midreset:dout", dout, 1'b0);
        check_regs("midreset");

        send_frame("recover", 32'h0A0F, 16, 1'b0, dseq);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
